// File: rtl/e6_out_logger.sv
// ---------------------------------------------------------------------------
// e6_out_logger
//
// Watches the e6 controller's output vector (y20..y1) and:
//   * logs every cycle in which the vector changes, together with a 16-bit
//     cycle stamp, into a show-ahead FIFO drained by a host over valid/ready;
//   * compacts every sampled vector into a 16-bit MISR signature, so golden
//     and suspect controllers can be compared without reading the full trace.
//
// Ports:
//   clk       in   clock, all state changes on posedge
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear, same effect as rst, wins over all else
//   en        in   sample enable; low freezes stamp, MISR, counters, prev_y
//   y_in      in   [W-1:0] controller output vector (stable at posedge)
//   rd_valid  out  FIFO head valid (FIFO not empty)
//   rd_ready  in   host accepts head entry
//   rd_data   out  [W-1:0] logged vector at FIFO head (0 when empty)
//   rd_stamp  out  [15:0] cycle stamp of head entry (0 when empty)
//   sig       out  [15:0] current MISR signature
//   evt_cnt   out  [15:0] change events detected, wraps
//   ovf_cnt   out  [7:0] dropped events, saturates at 255
//   halted    out  high while logging is halted after an overflow
//   full      out  FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module e6_out_logger #(
    parameter int          W           = 20,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] POLY        = 16'h1021,
    parameter int          HALT_ON_OVF = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] y_in,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [15:0]  rd_stamp,
    output logic [15:0]  sig,
    output logic [15:0]  evt_cnt,
    output logic [7:0]   ovf_cnt,
    output logic         halted,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // One MISR step: shift with polynomial feedback, then xor in the vector
    // folded down to 16 bits (bits above 15 wrap onto the low bits).
    function automatic logic [15:0] misr_step(input logic [15:0] s,
                                              input logic [W-1:0] y);
        logic [15:0] fold;
        fold = 16'h0000;
        for (int i = 0; i < W; i++) begin
            fold[i % 16] = fold[i % 16] ^ y[i];
        end
        misr_step = ({s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000)) ^ fold;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    prev_y_r;
    logic [15:0]     stamp_r;
    logic [15:0]     sig_r;
    logic [15:0]     evt_cnt_r;
    logic [7:0]      ovf_cnt_r;
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [W-1:0]    mem_data_r  [DEPTH];
    logic [15:0]     mem_stamp_r [DEPTH];

    logic            event_s;
    logic            empty_s;
    logic            full_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;
    logic [AW-1:0]   wr_idx_s;
    logic [AW-1:0]   rd_idx_s;

    assign wr_idx_s = wr_ptr_r[AW-1:0];
    assign rd_idx_s = rd_ptr_r[AW-1:0];

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign event_s  = en && (y_in != prev_y_r);

    // Draining is independent of en and of the halt state; a ready while
    // empty does nothing.
    assign pop_s    = (!empty_s) && rd_ready;

    // Next-state logic plus push/drop decisions for the current event.
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (event_s) begin
                    // A full FIFO can still accept when the head leaves
                    // in the same cycle.
                    if (!full_s || pop_s) begin
                        push_s  = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        drop_s = 1'b1;
                        if (HALT_ON_OVF != 0) begin
                            state_s = ST_HALT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                // Only clr or rst leave HALT.
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Control state: FSM, stamp, MISR, counters, previous vector, pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_RUN;
            prev_y_r  <= {W{1'b0}};
            stamp_r   <= 16'h0000;
            sig_r     <= 16'hFFFF;
            evt_cnt_r <= 16'h0000;
            ovf_cnt_r <= 8'h00;
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
        end else if (clr) begin
            state_r   <= ST_RUN;
            prev_y_r  <= {W{1'b0}};
            stamp_r   <= 16'h0000;
            sig_r     <= 16'hFFFF;
            evt_cnt_r <= 16'h0000;
            ovf_cnt_r <= 8'h00;
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
        end else begin
            state_r <= state_s;
            if (en) begin
                // prev_y follows every sampled vector, even dropped or
                // halted events, so each event is a true change.
                prev_y_r <= y_in;
                stamp_r  <= stamp_r + 16'd1;
                sig_r    <= misr_step(sig_r, y_in);
            end
            if (event_s) begin
                evt_cnt_r <= evt_cnt_r + 16'd1;
            end
            if (drop_s && (ovf_cnt_r != 8'hFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage; contents need no reset because the empty flag masks
    // the head outputs.
    always_ff @(posedge clk) begin
        if (push_s && !clr && !rst) begin
            mem_data_r[wr_idx_s]  <= y_in;
            // Entry carries the stamp value from before this cycle's increment.
            mem_stamp_r[wr_idx_s] <= stamp_r;
        end
    end

    // Show-ahead head outputs, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            rd_data  = {W{1'b0}};
            rd_stamp = 16'h0000;
        end else begin
            rd_data  = mem_data_r[rd_idx_s];
            rd_stamp = mem_stamp_r[rd_idx_s];
        end
    end

    assign rd_valid = !empty_s;
    assign full     = full_s;
    assign halted   = (state_r == ST_HALT);
    assign sig      = sig_r;
    assign evt_cnt  = evt_cnt_r;
    assign ovf_cnt  = ovf_cnt_r;

endmodule
